// File: rtl/bist_pkg.sv
// Shared BIST definitions: response width, default MISR constants and the
// analyzer state encoding. Imported by the analyzer and the MISR core.
package bist_pkg;

    localparam int unsigned BIST_RESP_W = 9;

    // Galois taps for x^9 + x^4 + 1, low BIST_RESP_W bits only
    localparam logic [BIST_RESP_W-1:0] BIST_POLY = 9'h011;
    localparam logic [BIST_RESP_W-1:0] BIST_SEED = 9'h000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2
    } bist_state_t;

endpackage

// File: rtl/misr_core.sv
// Galois-form multiple-input signature register.
// Ports: clk, reset (sync, active-high), load (sig<=SEED), en (absorb d), d, sig.
module misr_core
    import bist_pkg::*;
#(
    parameter int unsigned          WIDTH = BIST_RESP_W,
    parameter logic [WIDTH-1:0]     POLY  = BIST_POLY,
    parameter logic [WIDTH-1:0]     SEED  = BIST_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] fb;

    // Feedback is applied only when the bit shifted out is set
    assign fb = sig[WIDTH-1] ? POLY : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ fb ^ d;
        end
    end

endmodule

// File: rtl/bist_misr_analyzer.sv
// Response-side ALU BIST analyzer: compresses responses into a MISR, counts
// per-sample mismatches against the expected ROM word and reports pass/fail.
// Ports: clk, reset, start, data_valid, data_in, exp_data, golden_sig in;
//        busy, done, pass, signature, err_count, sample_cnt out.
module bist_misr_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH      = BIST_RESP_W,
    parameter logic [WIDTH-1:0] POLY       = BIST_POLY,
    parameter logic [WIDTH-1:0] SEED       = BIST_SEED,
    parameter int unsigned      N_PATTERNS = 256,
    parameter int unsigned      ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [WIDTH-1:0] golden_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      sample_cnt
);

    localparam logic [15:0]      LAST    = 16'(N_PATTERNS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    bist_state_t state;
    logic        misr_load;
    logic        misr_en;
    logic        mismatch;

    assign misr_load = (state == S_IDLE) && start;
    assign misr_en   = (state == S_RUN) && data_valid;
    assign mismatch  = (data_in != exp_data);
    assign busy      = (state != S_IDLE);

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (misr_load),
        .en    (misr_en),
        .d     (data_in),
        .sig   (signature)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            sample_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count  <= '0;
                        sample_cnt <= '0;
                        pass       <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (data_valid) begin
                        // Saturate rather than wrap so a huge fault count
                        // can never alias back to zero
                        if (mismatch && (err_count != ERR_MAX)) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        sample_cnt <= sample_cnt + 16'd1;
                        if (sample_cnt == LAST) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    pass  <= (signature == golden_sig) && (err_count == '0);
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Self-checking bench for bist_misr_analyzer: three instances (N=4, N=6 with
// 2-bit error counter, N=1) checked every cycle against a behavioural model.
module tb_bist_misr_analyzer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [3];
    logic        dv;
    logic [8:0]  din;
    logic [8:0]  expd;
    logic [8:0]  golden;

    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic [8:0]  sig  [3];
    logic [7:0]  errc [3];
    logic [15:0] cnt  [3];

    logic [7:0]  err_a;
    logic [1:0]  err_b;
    logic [7:0]  err_c;

    always #5 clk = ~clk;

    bist_misr_analyzer #(.N_PATTERNS(4), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .data_valid(dv),
        .data_in(din), .exp_data(expd), .golden_sig(golden),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .signature(sig[0]), .err_count(err_a), .sample_cnt(cnt[0])
    );

    bist_misr_analyzer #(.N_PATTERNS(6), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .data_valid(dv),
        .data_in(din), .exp_data(expd), .golden_sig(golden),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .signature(sig[1]), .err_count(err_b), .sample_cnt(cnt[1])
    );

    bist_misr_analyzer #(.N_PATTERNS(1), .ERR_W(8)) dut_c (
        .clk(clk), .reset(reset), .start(start[2]), .data_valid(dv),
        .data_in(din), .exp_data(expd), .golden_sig(golden),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .signature(sig[2]), .err_count(err_c), .sample_cnt(cnt[2])
    );

    assign errc[0] = err_a;
    assign errc[1] = {6'b0, err_b};
    assign errc[2] = err_c;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", nm, act, req);
        end
    endtask

    // Signature update as polynomial arithmetic: s*x mod (x^9+x^4+1), plus d
    function automatic logic [8:0] poly_step(input logic [8:0] s,
                                             input logic [8:0] d);
        logic [9:0] p;
        p = {s, 1'b0};
        if (p[9]) p = p ^ 10'h211;
        return p[8:0] ^ d;
    endfunction

    // Behavioural model: phase 0 idle, 1 collecting, 2 verdict pending
    int         np   [3] = '{4, 6, 1};
    int         emax [3] = '{255, 3, 255};
    int         ph   [3];
    logic [8:0] ms   [3];
    int         me   [3];
    int         mc   [3];
    logic       mp   [3];
    logic       md   [3];
    bit         armed = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        armed <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                ph[i] <= 0; ms[i] <= 9'h000; me[i] <= 0;
                mc[i] <= 0; mp[i] <= 1'b0;   md[i] <= 1'b0;
            end else begin
                md[i] <= 1'b0;
                if (ph[i] == 0) begin
                    if (start[i]) begin
                        ms[i] <= 9'h000; me[i] <= 0; mc[i] <= 0;
                        mp[i] <= 1'b0;   ph[i] <= 1;
                    end
                end else if (ph[i] == 1) begin
                    if (dv) begin
                        ms[i] <= poly_step(ms[i], din);
                        if (din != expd && me[i] < emax[i]) me[i] <= me[i] + 1;
                        mc[i] <= mc[i] + 1;
                        if (mc[i] + 1 == np[i]) ph[i] <= 2;
                    end
                end else begin
                    mp[i] <= (ms[i] == golden) && (me[i] == 0);
                    md[i] <= 1'b1;
                    ph[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("c%0d_u%0d_busy", cyc, i), busy[i], ph[i] != 0);
                chk($sformatf("c%0d_u%0d_done", cyc, i), done[i], md[i]);
                chk($sformatf("c%0d_u%0d_pass", cyc, i), pass[i], mp[i]);
                chk($sformatf("c%0d_u%0d_sig", cyc, i), sig[i], ms[i]);
                chk($sformatf("c%0d_u%0d_err", cyc, i), errc[i], me[i]);
                chk($sformatf("c%0d_u%0d_cnt", cyc, i), cnt[i], mc[i]);
            end
        end
    end

    logic [8:0] td [4] = '{9'h1A5, 9'h03C, 9'h100, 9'h0FF};
    logic [8:0] te [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i, output int t0);
        start[i] = 1'b1;
        t0 = cyc;
        tick();
        start[i] = 1'b0;
    endtask

    // Feeds td/te, consuming one sample per '1' in vpat (LSB first)
    task automatic feed(input int nbits, input logic [15:0] vpat);
        int k = 0;
        for (int b = 0; b < nbits; b++) begin
            dv = vpat[b];
            if (vpat[b]) begin
                din = td[k]; expd = te[k]; k++;
            end else begin
                din = 9'h1FF; expd = 9'h000;
            end
            tick();
        end
        dv = 1'b0;
    endtask

    task automatic wait_done(input int i, input string nm, output int t1);
        int k = 0;
        while (!done[i] && k < 20) begin
            tick();
            k++;
        end
        t1 = cyc;
        chk({nm, "_done_seen"}, done[i], 1);
    endtask

    int t0, t1, lat2, lat4;

    initial begin
        reset = 1'b1;
        foreach (start[i]) start[i] = 1'b0;
        dv = 1'b0; din = '0; expd = '0;
        golden = 9'h150;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_sig", sig[0], 9'h000);
        chk("rst_busy", busy[0], 0);
        chk("rst_pass", pass[0], 0);
        chk("model_pin_sig", poly_step(poly_step(poly_step(poly_step(
            9'h0, 9'h1A5), 9'h03C), 9'h100), 9'h0FF), 9'h150);

        // 1: basic MISR step
        pulse_start(0, t0);
        dv = 1'b1; din = 9'h100; expd = 9'h100;
        tick();
        chk("t1_sig1", sig[0], 9'h100);
        din = 9'h000; expd = 9'h000;
        tick();
        chk("t1_sig2", sig[0], 9'h011);
        feed(2, 16'b11);
        wait_done(0, "t1", t1);
        tick();

        // 2: full clean run
        te = td;
        pulse_start(0, t0);
        feed(4, 16'b1111);
        wait_done(0, "t2", t1);
        lat2 = t1 - t0;
        chk("t2_pass", pass[0], 1);
        chk("t2_err", errc[0], 0);
        chk("t2_cnt", cnt[0], 4);
        chk("t2_sig", sig[0], 9'h150);
        tick();
        chk("t2_done_one", done[0], 0);

        // 3: single fault on sample 2
        td[1] = 9'h03D;
        pulse_start(0, t0);
        feed(4, 16'b1111);
        wait_done(0, "t3", t1);
        chk("t3_err", errc[0], 1);
        chk("t3_pass", pass[0], 0);
        chk("t3_sig_ne", sig[0] != 9'h150, 1);
        td[1] = 9'h03C;
        tick();

        // 4: stalls 1,0,0,1,1,0,1
        pulse_start(0, t0);
        feed(7, 16'b1011001);
        wait_done(0, "t4", t1);
        lat4 = t1 - t0;
        chk("t4_sig", sig[0], 9'h150);
        chk("t4_err", errc[0], 0);
        chk("t4_cnt", cnt[0], 4);
        chk("t4_pass", pass[0], 1);
        chk("t4_delay", lat4 - lat2, 3);
        tick();

        // 5: saturation with a 2-bit counter
        pulse_start(1, t0);
        dv = 1'b1;
        for (int j = 0; j < 6; j++) begin
            din = 9'(j); expd = ~9'(j);
            tick();
        end
        dv = 1'b0;
        wait_done(1, "t5", t1);
        chk("t5_err", errc[1], 3);
        chk("t5_cnt", cnt[1], 6);
        chk("t5_pass", pass[1], 0);
        tick();

        // single-sample run
        pulse_start(2, t0);
        dv = 1'b1; din = 9'h150; expd = 9'h150;
        tick();
        dv = 1'b0;
        wait_done(2, "n1", t1);
        chk("n1_cnt", cnt[2], 1);
        chk("n1_pass", pass[2], 1);
        tick();

        // 6a: reset after two samples
        td[0] = 9'h001; td[1] = 9'h002;
        pulse_start(0, t0);
        feed(2, 16'b11);
        chk("t6_err_pre", errc[0], 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", busy[0], 0);
        chk("t6_sig", sig[0], 9'h000);
        chk("t6_err", errc[0], 0);
        chk("t6_cnt", cnt[0], 0);
        chk("t6_pass", pass[0], 0);
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (done[0]) seen++;
            end
            chk("t6_no_done", seen, 0);
        end

        // 6b: start on the done cycle
        td = '{9'h1A5, 9'h03C, 9'h100, 9'h0FF};
        pulse_start(0, t0);
        feed(4, 16'b1111);
        wait_done(0, "t6b", t1);
        chk("t6b_pass_before", pass[0], 1);
        pulse_start(0, t0);
        chk("t6b_pass_clr", pass[0], 0);
        chk("t6b_busy", busy[0], 1);
        chk("t6b_cnt", cnt[0], 0);
        feed(4, 16'b1111);
        wait_done(0, "t6b2", t1);
        chk("t6b_pass_again", pass[0], 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
